// File: rtl/vx_issue_arb_scalar.sv
// vx_issue_arb_scalar
// Drains ISSUE_CNT instruction-buffer channels. Each channel head is checked
// against a per-warp register scoreboard. One hazard-free head per cycle is
// granted round-robin into a single registered output stage. Destination
// registers stay pending until writeback retires them.

`ifndef NUM_WARPS
`define NUM_WARPS 8
`endif

module vx_issue_arb_scalar #(
    parameter int WARP_CNT    = `NUM_WARPS,
    parameter int ISSUE_CNT   = (WARP_CNT < 4) ? WARP_CNT : 4,
    parameter int ISSUE_WIS_W = ((WARP_CNT / ISSUE_CNT) > 1) ? $clog2(WARP_CNT / ISSUE_CNT) : 1,
    parameter int NUM_REGS    = 32,
    parameter int DATAW       = 128,
    localparam int NR_BITS    = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1,
    localparam int WID_W      = (WARP_CNT > 1) ? $clog2(WARP_CNT) : 1
) (
    input  logic                             i_clk,
    input  logic                             i_reset,
    input  logic [ISSUE_CNT-1:0]             i_flush,
    input  logic [ISSUE_CNT-1:0]             i_ibuf_valid,
    output logic [ISSUE_CNT-1:0]             o_ibuf_ready,
    input  logic [ISSUE_CNT*ISSUE_WIS_W-1:0] i_ibuf_wis,
    input  logic [ISSUE_CNT-1:0]             i_ibuf_wb,
    input  logic [ISSUE_CNT*NR_BITS-1:0]     i_ibuf_rd,
    input  logic [ISSUE_CNT*NR_BITS-1:0]     i_ibuf_rs1,
    input  logic [ISSUE_CNT*NR_BITS-1:0]     i_ibuf_rs2,
    input  logic [ISSUE_CNT*NR_BITS-1:0]     i_ibuf_rs3,
    input  logic [ISSUE_CNT*DATAW-1:0]       i_ibuf_data,
    input  logic                             i_wb_valid,
    input  logic [WID_W-1:0]                 i_wb_wid,
    input  logic [NR_BITS-1:0]               i_wb_rd,
    output logic                             o_issue_valid,
    input  logic                             i_issue_ready,
    output logic [WID_W-1:0]                 o_issue_wid,
    output logic [DATAW-1:0]                 o_issue_data
);

    localparam int SLOT_W = (ISSUE_CNT > 1) ? $clog2(ISSUE_CNT) : 1;

    // Scoreboard: one pending bit per (warp, register).
    logic [WARP_CNT-1:0][NUM_REGS-1:0] r_pending;
    logic [WARP_CNT-1:0][NUM_REGS-1:0] w_pending_next;

    // Round-robin start position.
    logic [SLOT_W-1:0] r_rr_ptr;
    logic [SLOT_W-1:0] w_rr_next;

    // Output stage. Slot/rd/wb are kept so a flush can cancel the held
    // instruction and give back its scoreboard bit.
    logic              r_issue_valid;
    logic [WID_W-1:0]  r_issue_wid;
    logic [DATAW-1:0]  r_issue_data;
    logic [SLOT_W-1:0] r_issue_slot;
    logic [NR_BITS-1:0] r_issue_rd;
    logic              r_issue_wb;

    // Per-slot decoded head fields.
    logic [WID_W-1:0]   w_wid  [ISSUE_CNT];
    logic [NR_BITS-1:0] w_rd   [ISSUE_CNT];
    logic [DATAW-1:0]   w_data [ISSUE_CNT];
    logic [ISSUE_CNT-1:0] w_eligible;

    // Arbitration results.
    logic               w_stage_free;
    logic               w_grant_any;
    logic [SLOT_W-1:0]  w_grant_slot;
    logic [WID_W-1:0]   w_win_wid;
    logic [NR_BITS-1:0] w_win_rd;
    logic               w_win_wb;
    logic [DATAW-1:0]   w_win_data;
    logic               w_win_sets_sb;
    logic               w_flush_held;

    // The output stage can take a new instruction when empty or draining.
    assign w_stage_free = ~r_issue_valid | i_issue_ready;

    // A held instruction whose slot is flushed and which is not accepted
    // this cycle is cancelled.
    assign w_flush_held = r_issue_valid & ~i_issue_ready & i_flush[r_issue_slot];

    genvar gi;
    generate
        for (gi = 0; gi < ISSUE_CNT; gi++) begin : g_slot
            logic [ISSUE_WIS_W-1:0] w_wis;
            logic [NR_BITS-1:0]     w_rs1;
            logic [NR_BITS-1:0]     w_rs2;
            logic [NR_BITS-1:0]     w_rs3;
            logic                   w_rs1_busy;
            logic                   w_rs2_busy;
            logic                   w_rs3_busy;
            logic                   w_rd_busy;

            assign w_wis     = i_ibuf_wis[gi*ISSUE_WIS_W +: ISSUE_WIS_W];
            assign w_rs1     = i_ibuf_rs1[gi*NR_BITS +: NR_BITS];
            assign w_rs2     = i_ibuf_rs2[gi*NR_BITS +: NR_BITS];
            assign w_rs3     = i_ibuf_rs3[gi*NR_BITS +: NR_BITS];
            assign w_rd[gi]  = i_ibuf_rd[gi*NR_BITS +: NR_BITS];
            assign w_data[gi] = i_ibuf_data[gi*DATAW +: DATAW];

            // Warps are interleaved across slots: wid = wis*ISSUE_CNT + slot.
            assign w_wid[gi] = WID_W'(w_wis) * WID_W'(ISSUE_CNT) + WID_W'(gi);

            // Register 0 is hardwired and never treated as pending.
            assign w_rs1_busy = (w_rs1 != '0) && r_pending[w_wid[gi]][w_rs1];
            assign w_rs2_busy = (w_rs2 != '0) && r_pending[w_wid[gi]][w_rs2];
            assign w_rs3_busy = (w_rs3 != '0) && r_pending[w_wid[gi]][w_rs3];
            assign w_rd_busy  = i_ibuf_wb[gi] && (w_rd[gi] != '0)
                                && r_pending[w_wid[gi]][w_rd[gi]];

            // RAW on any source or WAW on the destination blocks the head.
            assign w_eligible[gi] = i_ibuf_valid[gi] & ~i_flush[gi]
                                    & ~w_rs1_busy & ~w_rs2_busy & ~w_rs3_busy
                                    & ~w_rd_busy;

            // Pop strobe is one-hot on the winner and forced low in reset.
            assign o_ibuf_ready[gi] = ~i_reset & w_grant_any
                                      & (w_grant_slot == SLOT_W'(gi));
        end
    endgenerate

    // Round-robin pick: first eligible slot at or after r_rr_ptr, wrapping.
    always_comb begin
        w_grant_any  = 1'b0;
        w_grant_slot = '0;
        for (int k = 0; k < ISSUE_CNT; k++) begin
            if (!w_grant_any && w_stage_free
                && w_eligible[(int'(r_rr_ptr) + k) % ISSUE_CNT]) begin
                w_grant_any  = 1'b1;
                w_grant_slot = SLOT_W'((int'(r_rr_ptr) + k) % ISSUE_CNT);
            end
        end
    end

    assign w_win_wid     = w_wid[w_grant_slot];
    assign w_win_rd      = w_rd[w_grant_slot];
    assign w_win_wb      = i_ibuf_wb[w_grant_slot];
    assign w_win_data    = w_data[w_grant_slot];
    assign w_win_sets_sb = w_grant_any & w_win_wb & (w_win_rd != '0);

    // The pointer moves just past the winner so the next search starts there.
    assign w_rr_next = (w_grant_slot == SLOT_W'(ISSUE_CNT - 1))
                       ? '0 : w_grant_slot + SLOT_W'(1);

    // Scoreboard update: clears first, then the grant's set, so set wins on a collision.
    always_comb begin
        w_pending_next = r_pending;
        if (i_wb_valid) begin
            w_pending_next[i_wb_wid][i_wb_rd] = 1'b0;
        end
        if (w_flush_held && r_issue_wb) begin
            w_pending_next[r_issue_wid][r_issue_rd] = 1'b0;
        end
        if (w_win_sets_sb) begin
            w_pending_next[w_win_wid][w_win_rd] = 1'b1;
        end
    end

    // Scoreboard register.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_pending <= '0;
        end else begin
            r_pending <= w_pending_next;
        end
    end

    // Round-robin pointer advances only on a grant.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_rr_ptr <= '0;
        end else if (w_grant_any) begin
            r_rr_ptr <= w_rr_next;
        end
    end

    // Output stage: load on grant, hold while stalled, drop on accept or flush.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_issue_valid <= 1'b0;
            r_issue_wid   <= '0;
            r_issue_data  <= '0;
            r_issue_slot  <= '0;
            r_issue_rd    <= '0;
            r_issue_wb    <= 1'b0;
        end else if (w_grant_any) begin
            r_issue_valid <= 1'b1;
            r_issue_wid   <= w_win_wid;
            r_issue_data  <= w_win_data;
            r_issue_slot  <= w_grant_slot;
            r_issue_rd    <= w_win_rd;
            r_issue_wb    <= w_win_wb;
        end else if (w_flush_held || i_issue_ready) begin
            r_issue_valid <= 1'b0;
        end
    end

    assign o_issue_valid = r_issue_valid;
    assign o_issue_wid   = r_issue_wid;
    assign o_issue_data  = r_issue_data;

endmodule
